axis_sync_fifo: RTL and testbench
=================================

// Module: axis_sync_fifo
// PURPOSE
//  Single-clock AXI-Stream FIFO placed directly downstream of any axis master.
//  Buffers DEPTH full beats (tdata/tstrb/tkeep/tlast/tid/tdest/tuser), decouples back-pressure.
//  Optional store-and-forward packet mode: output only once a whole packet (tlast) is stored.
//  Slave side connects to an axis.slave modport; master side to an axis.master modport.
// PARAMETERS
//  DATA_WIDTH   32  tdata width, multiple of 8; tstrb/tkeep width = DATA_WIDTH/8
//  ID_WIDTH     1   tid width
//  DEST_WIDTH   1   tdest width
//  USER_WIDTH   1   tuser width
//  DEPTH        16  beat capacity, power of 2, >= 4
//  PACKET_MODE  0   1 = store-and-forward on tlast, 0 = cut-through
//  AFULL_LVL    12  almost_full asserts when count >= AFULL_LVL (1..DEPTH)
// PORTS
//  clk          in   1                    single clock, all logic rising-edge
//  rst          in   1                    synchronous reset, active-high
//  s_axis       -    axis.slave           upstream beats (tvalid/tdata/.../tready)
//  m_axis       -    axis.master          downstream beats
//  count        out  $clog2(DEPTH)+1      beats stored, incl. output register
//  pkt_count    out  $clog2(DEPTH)+1      complete packets (tlast beats) stored
//  almost_full  out  1                    count >= AFULL_LVL
// BEHAVIOUR
//  Reset (rst=1 at clk edge): pointers, count, pkt_count = 0; m_axis.tvalid=0;
//   s_axis.tready=0 while rst=1, =1 on first cycle after release; almost_full=0.
//  Accept: s_axis.tvalid & s_axis.tready. Consume: m_axis.tvalid & m_axis.tready.
//  s_axis.tready = (count < DEPTH) & ~rst; registered, no combinational path from m_axis.tready.
//  Full: tready=0; a consume while full frees a slot, tready=1 next cycle (no same-cycle pass-through).
//  Latency: beat accepted at cycle N into empty FIFO -> m_axis.tvalid=1 with that beat at N+1.
//  m_axis fields driven from an output register (first-word-fall-through); stable while tvalid & ~tready.
//  Simultaneous accept+consume: count unchanged; order strictly preserved.
//  Empty: m_axis.tvalid=0; m_axis.tdata etc. hold last value (don't-care for checks).
//  Pointers wrap modulo DEPTH; count = wr_ptr - rd_ptr using one extra MSB.
//  pkt_count: +1 on accept with tlast, -1 on consume with tlast, both -> unchanged.
//  PACKET_MODE=1: m_axis.tvalid only when pkt_count > 0 OR count == DEPTH
//   (oversize packet released cut-through to avoid deadlock); once a beat is presented,
//   streaming continues until that packet's tlast is consumed.
//  PACKET_MODE=0: pkt_count still maintained; m_axis.tvalid whenever count > 0.
//  Reset mid-packet: all stored beats discarded, no partial beat emitted after release.
// STRUCTURE
//  axis_pkg: typedef struct packed axis_beat_t {data,strb,keep,last,id,dest,user}
//   parameterised via localparams; helper function axis_beat_width().
//  Sub-module axis_fifo_ram: simple dual-port RAM, 1 write / 1 registered read port,
//   width = beat width, depth = DEPTH; top holds pointers, counters, output stage, FSM
//   (PACKET_MODE: IDLE -> STREAM on first release, STREAM -> IDLE on tlast consume).
// TESTING
//  1. Reset then write 0x11..0x14 (tlast on 0x14), m tready=1 -> out same order, first at +1 cycle, count 0 at end.
//  2. m tready=0, write 16 beats -> s tready=0 after 16th, count=16, almost_full=1 from 12th; then drain all 16 intact.
//  3. Full FIFO, accept+consume same cycle attempt -> no accept that cycle, tready=1 next, count 15->16.
//  4. PACKET_MODE=1: write 3 beats no tlast -> m tvalid=0; 4th beat tlast -> tvalid=1 next cycle, pkt_count=1.
//  5. PACKET_MODE=1, DEPTH=16: 20-beat packet -> released at count=16, all 20 beats out in order, no deadlock.
//  6. Reset asserted after 5 of 8 beats stored -> count=0, tvalid=0; new packet 0xA0 emitted alone, no stale beats.

Source files
------------

// File: rtl/axis_pkg.sv
// Shared AXI-Stream beat layout, beat-width helper and packet-release FSM states.
package axis_pkg;

   localparam int AXIS_DATA_W = 32;
   localparam int AXIS_KEEP_W = AXIS_DATA_W / 8;
   localparam int AXIS_ID_W   = 1;
   localparam int AXIS_DEST_W = 1;
   localparam int AXIS_USER_W = 1;

   typedef struct packed {
      logic [AXIS_DATA_W-1:0] data;
      logic [AXIS_KEEP_W-1:0] strb;
      logic [AXIS_KEEP_W-1:0] keep;
      logic                   last;
      logic [AXIS_ID_W-1:0]   id;
      logic [AXIS_DEST_W-1:0] dest;
      logic [AXIS_USER_W-1:0] user;
   } axis_beat_t;

   typedef enum logic [0:0] {
      ST_IDLE   = 1'b0,
      ST_STREAM = 1'b1
   } pkt_state_e;

   // Field order matches axis_beat_t: data, strb, keep, last, id, dest, user.
   function automatic int axis_beat_width(input int data_w, input int id_w,
                                          input int dest_w, input int user_w);
      return data_w + 2 * (data_w / 8) + 1 + id_w + dest_w + user_w;
   endfunction

endpackage

// File: rtl/axis.sv
// AXI-Stream bundle with master/slave views.
interface axis #(
   parameter int DATA_WIDTH = 32,
   parameter int ID_WIDTH   = 1,
   parameter int DEST_WIDTH = 1,
   parameter int USER_WIDTH = 1
);
   logic                    tvalid;
   logic                    tready;
   logic [DATA_WIDTH-1:0]   tdata;
   logic [DATA_WIDTH/8-1:0] tstrb;
   logic [DATA_WIDTH/8-1:0] tkeep;
   logic                    tlast;
   logic [ID_WIDTH-1:0]     tid;
   logic [DEST_WIDTH-1:0]   tdest;
   logic [USER_WIDTH-1:0]   tuser;

   modport master (output tvalid, tdata, tstrb, tkeep, tlast, tid, tdest, tuser,
                   input  tready);
   modport slave  (input  tvalid, tdata, tstrb, tkeep, tlast, tid, tdest, tuser,
                   output tready);
endinterface

// File: rtl/axis_fifo_ram.sv
// Simple dual-port beat store: one write port, one registered read port.
module axis_fifo_ram #(
   parameter int WIDTH = 48,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     wr_en_i,
   input  logic [$clog2(DEPTH)-1:0] wr_addr_i,
   input  logic [WIDTH-1:0]         wr_data_i,
   input  logic [$clog2(DEPTH)-1:0] rd_addr_i,
   output logic [WIDTH-1:0]         rd_data_o
);
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] rd_data_q;

   // Write-first on address collision so a beat written into an empty store
   // appears on the read register one cycle later.
   always_ff @(posedge clk) begin
      if (wr_en_i) begin
         mem_q[wr_addr_i] <= wr_data_i;
      end
      rd_data_q <= (wr_en_i && (wr_addr_i == rd_addr_i)) ? wr_data_i : mem_q[rd_addr_i];
   end

   assign rd_data_o = rd_data_q;

endmodule

// File: rtl/axis_sync_fifo.sv
// Single-clock AXI-Stream FIFO with first-word-fall-through output and optional
// store-and-forward packet release.
//
//   state     | meaning
//   ST_IDLE   | nothing presented yet; wait for a whole packet or a full store
//   ST_STREAM | a packet has started leaving; keep presenting until its tlast goes
module axis_sync_fifo
   import axis_pkg::*;
#(
   parameter int DATA_WIDTH  = 32,
   parameter int ID_WIDTH    = 1,
   parameter int DEST_WIDTH  = 1,
   parameter int USER_WIDTH  = 1,
   parameter int DEPTH       = 16,
   parameter int PACKET_MODE = 0,
   parameter int AFULL_LVL   = 12
) (
   input  logic                     clk,
   input  logic                     rst,
   axis.slave                       s_axis,
   axis.master                      m_axis,
   output logic [$clog2(DEPTH):0]   count,
   output logic [$clog2(DEPTH):0]   pkt_count,
   output logic                     almost_full
);
   localparam int AW = $clog2(DEPTH);
   localparam int KW = DATA_WIDTH / 8;
   localparam int BW = axis_beat_width(DATA_WIDTH, ID_WIDTH, DEST_WIDTH, USER_WIDTH);
   localparam logic [AW:0] FULL_CNT  = (AW + 1)'(DEPTH);
   localparam logic [AW:0] AFULL_CNT = (AW + 1)'(AFULL_LVL);

   typedef struct packed {
      logic [DATA_WIDTH-1:0] data;
      logic [KW-1:0]         strb;
      logic [KW-1:0]         keep;
      logic                  last;
      logic [ID_WIDTH-1:0]   id;
      logic [DEST_WIDTH-1:0] dest;
      logic [USER_WIDTH-1:0] user;
   } beat_t;

   logic [AW:0] wr_ptr_q, wr_ptr_d;
   logic [AW:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0] pkt_q, pkt_d;
   pkt_state_e  state_q, state_d;

   beat_t       wr_beat, rd_beat;
   logic [BW-1:0] rd_raw;
   logic        s_ready, m_valid;
   logic        accept, consume;
   logic        release_ok;

   assign count       = wr_ptr_q - rd_ptr_q;
   assign pkt_count   = pkt_q;
   assign almost_full = (count >= AFULL_CNT);

   assign s_ready = (count < FULL_CNT) & ~rst;
   assign accept  = s_axis.tvalid & s_ready;
   assign consume = m_valid & m_axis.tready;

   // A full store with no tlast can never complete a packet, so it is released anyway.
   assign release_ok = (PACKET_MODE == 0) || (state_q == ST_STREAM) ||
                       (pkt_q != '0) || (count == FULL_CNT);
   assign m_valid    = (count != '0) && release_ok;

   assign wr_beat = {s_axis.tdata, s_axis.tstrb, s_axis.tkeep, s_axis.tlast,
                     s_axis.tid, s_axis.tdest, s_axis.tuser};
   assign rd_beat = beat_t'(rd_raw);

   always_comb begin
      wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, accept};
      rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, consume};
      pkt_d    = pkt_q;
      if ((accept && s_axis.tlast) && !(consume && rd_beat.last)) begin
         pkt_d = pkt_q + 1'b1;
      end else if (!(accept && s_axis.tlast) && (consume && rd_beat.last)) begin
         pkt_d = pkt_q - 1'b1;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (m_valid && !(consume && rd_beat.last)) begin
               state_d = ST_STREAM;
            end
         end
         ST_STREAM: begin
            if (consume && rd_beat.last) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         pkt_q    <= '0;
         state_q  <= ST_IDLE;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         pkt_q    <= pkt_d;
         state_q  <= state_d;
      end
   end

   // The read register always holds the beat at the post-consume head, so it is
   // the output stage itself and the head beat stays counted until consumed.
   axis_fifo_ram #(
      .WIDTH (BW),
      .DEPTH (DEPTH)
   ) u_ram (
      .clk       (clk),
      .wr_en_i   (accept),
      .wr_addr_i (wr_ptr_q[AW-1:0]),
      .wr_data_i (wr_beat),
      .rd_addr_i (rd_ptr_d[AW-1:0]),
      .rd_data_o (rd_raw)
   );

   assign s_axis.tready = s_ready;
   assign m_axis.tvalid = m_valid;
   assign m_axis.tdata  = rd_beat.data;
   assign m_axis.tstrb  = rd_beat.strb;
   assign m_axis.tkeep  = rd_beat.keep;
   assign m_axis.tlast  = rd_beat.last;
   assign m_axis.tid    = rd_beat.id;
   assign m_axis.tdest  = rd_beat.dest;
   assign m_axis.tuser  = rd_beat.user;

endmodule

// File: tb/tb_axis_sync_fifo.sv
// Directed bench: cut-through instance (u_ct) and store-and-forward instance (u_pk).
module tb_axis_sync_fifo;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   axis #(.DATA_WIDTH(32), .ID_WIDTH(1), .DEST_WIDTH(1), .USER_WIDTH(1)) s0 (), m0 (), s1 (), m1 ();

   logic [4:0] cnt0, pkt0, cnt1, pkt1;
   logic       af0, af1;

   int n_cmp = 0;
   int n_err = 0;

   axis_sync_fifo #(
      .DATA_WIDTH(32), .ID_WIDTH(1), .DEST_WIDTH(1), .USER_WIDTH(1),
      .DEPTH(16), .PACKET_MODE(0), .AFULL_LVL(12)
   ) u_ct (
      .clk(clk), .rst(rst), .s_axis(s0), .m_axis(m0),
      .count(cnt0), .pkt_count(pkt0), .almost_full(af0)
   );

   axis_sync_fifo #(
      .DATA_WIDTH(32), .ID_WIDTH(1), .DEST_WIDTH(1), .USER_WIDTH(1),
      .DEPTH(16), .PACKET_MODE(1), .AFULL_LVL(12)
   ) u_pk (
      .clk(clk), .rst(rst), .s_axis(s1), .m_axis(m1),
      .count(cnt1), .pkt_count(pkt1), .almost_full(af1)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      s0.tvalid = 1'b0; s0.tdata = '0; s0.tstrb = 4'hF; s0.tkeep = 4'hF; s0.tlast = 1'b0;
      s0.tid = 1'b0; s0.tdest = 1'b0; s0.tuser = 1'b0; m0.tready = 1'b0;
      s1.tvalid = 1'b0; s1.tdata = '0; s1.tstrb = 4'hF; s1.tkeep = 4'hF; s1.tlast = 1'b0;
      s1.tid = 1'b0; s1.tdest = 1'b0; s1.tuser = 1'b0; m1.tready = 1'b0;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst = 1'b1;
      repeat (3) tick();
      n_cmp++; if (cnt0 !== 5'd0) begin n_err++; $display("FAIL reset_count got %0d exp 0", cnt0); end
      n_cmp++; if (pkt0 !== 5'd0) begin n_err++; $display("FAIL reset_pkt_count got %0d exp 0", pkt0); end
      n_cmp++; if (m0.tvalid !== 1'b0) begin n_err++; $display("FAIL reset_m_tvalid got %b exp 0", m0.tvalid); end
      n_cmp++; if (s0.tready !== 1'b0) begin n_err++; $display("FAIL reset_s_tready_in_rst got %b exp 0", s0.tready); end
      n_cmp++; if (af0 !== 1'b0) begin n_err++; $display("FAIL reset_almost_full got %b exp 0", af0); end
      n_cmp++; if (m1.tvalid !== 1'b0) begin n_err++; $display("FAIL reset_pk_m_tvalid got %b exp 0", m1.tvalid); end
      rst = 1'b0;
      #1;
      n_cmp++; if (s0.tready !== 1'b1) begin n_err++; $display("FAIL release_s_tready got %b exp 1", s0.tready); end
      n_cmp++; if (s1.tready !== 1'b1) begin n_err++; $display("FAIL release_pk_s_tready got %b exp 1", s1.tready); end
   endtask

   task automatic test_cut_through();
      m0.tready = 1'b1;
      n_cmp++; if (m0.tvalid !== 1'b0) begin n_err++; $display("FAIL ct_idle_tvalid got %b exp 0", m0.tvalid); end
      for (int i = 0; i < 4; i++) begin
         s0.tvalid = 1'b1;
         s0.tdata  = 32'h11 + i;
         s0.tuser  = i[0];
         s0.tlast  = (i == 3);
         tick();
         n_cmp++; if (m0.tvalid !== 1'b1) begin n_err++; $display("FAIL ct_tvalid[%0d] got %b exp 1", i, m0.tvalid); end
         n_cmp++; if (m0.tdata !== 32'h11 + i) begin n_err++; $display("FAIL ct_tdata[%0d] got %h exp %h", i, m0.tdata, 32'h11 + i); end
         n_cmp++; if (m0.tuser !== i[0]) begin n_err++; $display("FAIL ct_tuser[%0d] got %b exp %b", i, m0.tuser, i[0]); end
         n_cmp++; if (m0.tlast !== (i == 3)) begin n_err++; $display("FAIL ct_tlast[%0d] got %b exp %b", i, m0.tlast, (i == 3)); end
         n_cmp++; if (cnt0 !== 5'd1) begin n_err++; $display("FAIL ct_count[%0d] got %0d exp 1", i, cnt0); end
      end
      n_cmp++; if (pkt0 !== 5'd1) begin n_err++; $display("FAIL ct_pkt_count got %0d exp 1", pkt0); end
      s0.tvalid = 1'b0; s0.tlast = 1'b0; s0.tuser = 1'b0;
      tick();
      n_cmp++; if (cnt0 !== 5'd0) begin n_err++; $display("FAIL ct_end_count got %0d exp 0", cnt0); end
      n_cmp++; if (m0.tvalid !== 1'b0) begin n_err++; $display("FAIL ct_end_tvalid got %b exp 0", m0.tvalid); end
      n_cmp++; if (pkt0 !== 5'd0) begin n_err++; $display("FAIL ct_end_pkt_count got %0d exp 0", pkt0); end
      m0.tready = 1'b0;
   endtask

   task automatic test_fill_drain();
      m0.tready = 1'b0;
      for (int i = 0; i < 16; i++) begin
         s0.tvalid = 1'b1;
         s0.tdata  = 32'h100 + i;
         s0.tlast  = (i == 15);
         n_cmp++; if (s0.tready !== 1'b1) begin n_err++; $display("FAIL fill_s_tready[%0d] got %b exp 1", i, s0.tready); end
         tick();
         n_cmp++; if (cnt0 !== 5'(i + 1)) begin n_err++; $display("FAIL fill_count[%0d] got %0d exp %0d", i, cnt0, i + 1); end
         n_cmp++; if (af0 !== (i + 1 >= 12)) begin n_err++; $display("FAIL fill_almost_full[%0d] got %b exp %b", i, af0, (i + 1 >= 12)); end
      end
      n_cmp++; if (s0.tready !== 1'b0) begin n_err++; $display("FAIL full_s_tready got %b exp 0", s0.tready); end
      s0.tdata = 32'hDEAD; s0.tlast = 1'b0;
      repeat (2) tick();
      n_cmp++; if (cnt0 !== 5'd16) begin n_err++; $display("FAIL full_hold_count got %0d exp 16", cnt0); end
      n_cmp++; if (m0.tdata !== 32'h100) begin n_err++; $display("FAIL full_head_tdata got %h exp 100", m0.tdata); end
      s0.tvalid = 1'b0;
      m0.tready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         n_cmp++; if (m0.tvalid !== 1'b1) begin n_err++; $display("FAIL drain_tvalid[%0d] got %b exp 1", i, m0.tvalid); end
         n_cmp++; if (m0.tdata !== 32'h100 + i) begin n_err++; $display("FAIL drain_tdata[%0d] got %h exp %h", i, m0.tdata, 32'h100 + i); end
         tick();
      end
      n_cmp++; if (cnt0 !== 5'd0) begin n_err++; $display("FAIL drain_count got %0d exp 0", cnt0); end
      n_cmp++; if (m0.tvalid !== 1'b0) begin n_err++; $display("FAIL drain_tvalid_end got %b exp 0", m0.tvalid); end
      n_cmp++; if (af0 !== 1'b0) begin n_err++; $display("FAIL drain_almost_full got %b exp 0", af0); end
      m0.tready = 1'b0;
   endtask

   task automatic test_full_simul();
      logic [31:0] exp_d;
      m0.tready = 1'b0;
      for (int i = 0; i < 16; i++) begin
         s0.tvalid = 1'b1;
         s0.tdata  = 32'h300 + i;
         tick();
      end
      s0.tdata  = 32'h3AA;
      m0.tready = 1'b1;
      n_cmp++; if (s0.tready !== 1'b0) begin n_err++; $display("FAIL simul_s_tready_full got %b exp 0", s0.tready); end
      n_cmp++; if (m0.tdata !== 32'h300) begin n_err++; $display("FAIL simul_head got %h exp 300", m0.tdata); end
      tick();
      n_cmp++; if (cnt0 !== 5'd15) begin n_err++; $display("FAIL simul_count got %0d exp 15", cnt0); end
      n_cmp++; if (s0.tready !== 1'b1) begin n_err++; $display("FAIL simul_s_tready_next got %b exp 1", s0.tready); end
      m0.tready = 1'b0;
      tick();
      n_cmp++; if (cnt0 !== 5'd16) begin n_err++; $display("FAIL simul_refill_count got %0d exp 16", cnt0); end
      n_cmp++; if (s0.tready !== 1'b0) begin n_err++; $display("FAIL simul_refill_s_tready got %b exp 0", s0.tready); end
      s0.tvalid = 1'b0;
      m0.tready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         exp_d = (i < 15) ? 32'h301 + i : 32'h3AA;
         n_cmp++; if (m0.tdata !== exp_d) begin n_err++; $display("FAIL simul_drain[%0d] got %h exp %h", i, m0.tdata, exp_d); end
         tick();
      end
      n_cmp++; if (cnt0 !== 5'd0) begin n_err++; $display("FAIL simul_end_count got %0d exp 0", cnt0); end
      m0.tready = 1'b0;
   endtask

   task automatic test_reset_mid();
      m0.tready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         s0.tvalid = 1'b1;
         s0.tdata  = 32'h50 + i;
         s0.tlast  = 1'b0;
         tick();
      end
      n_cmp++; if (cnt0 !== 5'd5) begin n_err++; $display("FAIL rstmid_pre_count got %0d exp 5", cnt0); end
      s0.tvalid = 1'b0;
      rst = 1'b1;
      tick();
      n_cmp++; if (cnt0 !== 5'd0) begin n_err++; $display("FAIL rstmid_count got %0d exp 0", cnt0); end
      n_cmp++; if (m0.tvalid !== 1'b0) begin n_err++; $display("FAIL rstmid_tvalid got %b exp 0", m0.tvalid); end
      n_cmp++; if (pkt0 !== 5'd0) begin n_err++; $display("FAIL rstmid_pkt_count got %0d exp 0", pkt0); end
      rst = 1'b0;
      tick();
      n_cmp++; if (m0.tvalid !== 1'b0) begin n_err++; $display("FAIL rstmid_stale_tvalid got %b exp 0", m0.tvalid); end
      s0.tvalid = 1'b1; s0.tdata = 32'hA0; s0.tlast = 1'b1;
      m0.tready = 1'b1;
      tick();
      n_cmp++; if (m0.tvalid !== 1'b1) begin n_err++; $display("FAIL rstmid_new_tvalid got %b exp 1", m0.tvalid); end
      n_cmp++; if (m0.tdata !== 32'hA0) begin n_err++; $display("FAIL rstmid_new_tdata got %h exp a0", m0.tdata); end
      n_cmp++; if (m0.tlast !== 1'b1) begin n_err++; $display("FAIL rstmid_new_tlast got %b exp 1", m0.tlast); end
      s0.tvalid = 1'b0; s0.tlast = 1'b0;
      tick();
      n_cmp++; if (m0.tvalid !== 1'b0) begin n_err++; $display("FAIL rstmid_after_tvalid got %b exp 0", m0.tvalid); end
      n_cmp++; if (cnt0 !== 5'd0) begin n_err++; $display("FAIL rstmid_after_count got %0d exp 0", cnt0); end
      m0.tready = 1'b0;
   endtask

   task automatic test_packet_hold();
      m1.tready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         s1.tvalid = 1'b1;
         s1.tdata  = 32'h40 + i;
         s1.tlast  = 1'b0;
         tick();
         n_cmp++; if (m1.tvalid !== 1'b0) begin n_err++; $display("FAIL pkt_hold_tvalid[%0d] got %b exp 0", i, m1.tvalid); end
         n_cmp++; if (cnt1 !== 5'(i + 1)) begin n_err++; $display("FAIL pkt_hold_count[%0d] got %0d exp %0d", i, cnt1, i + 1); end
      end
      s1.tdata = 32'h43; s1.tlast = 1'b1;
      tick();
      n_cmp++; if (m1.tvalid !== 1'b1) begin n_err++; $display("FAIL pkt_release_tvalid got %b exp 1", m1.tvalid); end
      n_cmp++; if (pkt1 !== 5'd1) begin n_err++; $display("FAIL pkt_release_pkt_count got %0d exp 1", pkt1); end
      n_cmp++; if (cnt1 !== 5'd4) begin n_err++; $display("FAIL pkt_release_count got %0d exp 4", cnt1); end
      s1.tvalid = 1'b0; s1.tlast = 1'b0;
      for (int i = 0; i < 4; i++) begin
         n_cmp++; if (m1.tvalid !== 1'b1) begin n_err++; $display("FAIL pkt_stream_tvalid[%0d] got %b exp 1", i, m1.tvalid); end
         n_cmp++; if (m1.tdata !== 32'h40 + i) begin n_err++; $display("FAIL pkt_stream_tdata[%0d] got %h exp %h", i, m1.tdata, 32'h40 + i); end
         tick();
      end
      n_cmp++; if (cnt1 !== 5'd0) begin n_err++; $display("FAIL pkt_end_count got %0d exp 0", cnt1); end
      n_cmp++; if (pkt1 !== 5'd0) begin n_err++; $display("FAIL pkt_end_pkt_count got %0d exp 0", pkt1); end
      n_cmp++; if (m1.tvalid !== 1'b0) begin n_err++; $display("FAIL pkt_end_tvalid got %b exp 0", m1.tvalid); end
      m1.tready = 1'b0;
   endtask

   task automatic test_oversize();
      int  in_idx  = 0;
      int  out_idx = 0;
      bit  acc, con;
      m1.tready = 1'b1;
      s1.tvalid = 1'b1; s1.tdata = 32'h600; s1.tlast = 1'b0;
      for (int cyc = 0; cyc < 200 && out_idx < 20; cyc++) begin
         acc = s1.tvalid && s1.tready;
         con = m1.tvalid && m1.tready;
         if (con) begin
            if (out_idx == 0) begin
               n_cmp++; if (cnt1 !== 5'd16) begin n_err++; $display("FAIL big_release_count got %0d exp 16", cnt1); end
            end
            n_cmp++; if (m1.tdata !== 32'h600 + out_idx) begin n_err++; $display("FAIL big_tdata[%0d] got %h exp %h", out_idx, m1.tdata, 32'h600 + out_idx); end
            n_cmp++; if (m1.tlast !== (out_idx == 19)) begin n_err++; $display("FAIL big_tlast[%0d] got %b exp %b", out_idx, m1.tlast, (out_idx == 19)); end
            out_idx++;
         end
         tick();
         if (acc) in_idx++;
         s1.tvalid = (in_idx < 20);
         s1.tdata  = 32'h600 + in_idx;
         s1.tlast  = (in_idx == 19);
      end
      n_cmp++; if (out_idx != 20) begin n_err++; $display("FAIL big_beats_out got %0d exp 20", out_idx); end
      s1.tvalid = 1'b0; s1.tlast = 1'b0;
      n_cmp++; if (cnt1 !== 5'd0) begin n_err++; $display("FAIL big_end_count got %0d exp 0", cnt1); end
      n_cmp++; if (pkt1 !== 5'd0) begin n_err++; $display("FAIL big_end_pkt_count got %0d exp 0", pkt1); end
      m1.tready = 1'b0;
   endtask

   initial begin
      test_reset();
      test_cut_through();
      test_fill_drain();
      test_full_simul();
      test_reset_mid();
      test_packet_hold();
      test_oversize();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired before bench completion");
      $fatal(1, "watchdog");
   end

endmodule
